// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: icache, dcache and physical-memory line ports of the cache arbiter.
interface cache_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;
  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [LINE_W-1:0] dcache_wdata;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  modport slave (
    input  icache_read, icache_address, dcache_read, dcache_write, dcache_address, dcache_wdata,
           pmem_rdata, pmem_resp,
    output icache_rdata, icache_resp, dcache_rdata, dcache_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
  modport master (
    output icache_read, icache_address, dcache_read, dcache_write, dcache_address, dcache_wdata,
           pmem_rdata, pmem_resp,
    input  icache_rdata, icache_resp, dcache_rdata, dcache_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/cache_arbiter.sv
// cache_arbiter: grants the memory line port to icache or dcache, one whole transaction at a time.
// CACHE_ARB_ROUND_ROBIN_EN selects round-robin contention instead of fixed dcache priority.
module cache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic            clk,
  input  logic            rst,
  cache_arbiter_if.slave  bus_io
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;
  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              d_req, pick_d, serve_i, serve_d;
  logic [ADDR_W-1:0] addr_mux;
  logic [LINE_W-1:0] wdata_mux;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
  assign pick_d = ~last_grant_q;
`else
  assign pick_d = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    d_req        = bus_io.dcache_read | bus_io.dcache_write;
    if (state_q == IDLE)
      state_d = (d_req & (pick_d | ~bus_io.icache_read)) ? SERVE_D :
                bus_io.icache_read ? SERVE_I : IDLE;
    else if (bus_io.pmem_resp) begin
      state_d      = IDLE;
      last_grant_d = (state_q == SERVE_D);
    end
  end
  // outputs are gated by rst so they read 0 during reset even before the first edge
  always_comb begin
    serve_i   = ~rst & (state_q == SERVE_I);
    serve_d   = ~rst & (state_q == SERVE_D);
    addr_mux  = serve_i ? bus_io.icache_address : serve_d ? bus_io.dcache_address : '0;
    wdata_mux = serve_d ? bus_io.dcache_wdata : '0;
  end
  assign bus_io.pmem_read    = serve_i | (serve_d & bus_io.dcache_read & ~bus_io.dcache_write);
  assign bus_io.pmem_write   = serve_d & bus_io.dcache_write;
  assign bus_io.pmem_address = addr_mux;
  assign bus_io.pmem_wdata   = wdata_mux;
  assign bus_io.icache_rdata = serve_i ? bus_io.pmem_rdata : '0;
  assign bus_io.icache_resp  = serve_i & bus_io.pmem_resp;
  assign bus_io.dcache_rdata = serve_d ? bus_io.pmem_rdata : '0;
  assign bus_io.dcache_resp  = serve_d & bus_io.pmem_resp;
endmodule
